// File: rtl/sb_ctrl.sv
// Stream-buffer controller: looks up miss lines against the sb_cell tags and keeps the cells prefetching sequential lines.
// Optional hit/miss counters are enabled by defining SB_CTRL_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module sb_ctrl #(
  parameter int NUM_CELLS          = 4,
  parameter int LINE_SIZE          = 4,
  parameter int BLOCK_OFFSET_WIDTH = 2,
  parameter int LINE_AW            = `ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [LINE_AW-1:0]                          req_line_addr,
  output logic                                        resp_valid,
  output logic                                        resp_hit,
  output logic [LINE_SIZE*`DATA_WIDTH-1:0]            resp_data,
  output logic [NUM_CELLS-1:0]                        cell_enable,
  output logic [`ADDR_WIDTH-3:0]                      cell_addr,
  output logic [NUM_CELLS-1:0]                        cell_stale,
  input  logic [NUM_CELLS-1:0]                        cell_available,
  input  logic [NUM_CELLS-1:0]                        cell_idle,
  input  logic [NUM_CELLS*LINE_SIZE*`DATA_WIDTH-1:0]  cell_rdata
`ifdef SB_CTRL_STATS_EN
  ,
  output logic [31:0]                                 stat_hits,
  output logic [31:0]                                 stat_misses
`endif
);

  localparam int IDX_W  = $clog2(NUM_CELLS);
  localparam int LINE_W = LINE_SIZE * `DATA_WIDTH;

  typedef enum logic [1:0] {E_INVALID = 2'd0, E_FILL = 2'd1, E_VALID = 2'd2, E_DRAIN = 2'd3} ent_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_FILL = 2'd1, S_FLUSH = 2'd2, S_ALLOC = 2'd3} state_t;

  state_t             state;
  ent_t               ent       [NUM_CELLS];
  logic [LINE_AW-1:0] tag       [NUM_CELLS];
  logic [LINE_W-1:0]  cell_line [NUM_CELLS];
  logic [LINE_AW-1:0] next_addr;
  logic [LINE_AW-1:0] miss_addr;
  logic [IDX_W-1:0]   alloc_idx;
  logic [IDX_W-1:0]   wait_idx;

  logic               accept;
  logic               match_found;
  logic               match_valid;
  logic [IDX_W-1:0]   match_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               do_hit;

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_line
    assign cell_line[g] = cell_rdata[g*LINE_W +: LINE_W];
  end

  // Readiness is a pure decode of the FSM state, forced low while reset is held.
  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Tag lookup over live entries; scanning downward lets the lowest index win.
  always_comb begin
    match_found = 1'b0;
    match_valid = 1'b0;
    match_idx   = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if ((ent[i] == E_VALID || ent[i] == E_FILL) && tag[i] == req_line_addr) begin
        match_found = 1'b1;
        match_valid = (ent[i] == E_VALID);
        match_idx   = IDX_W'(i);
      end else begin
        match_found = match_found;
      end
    end
  end

  // A hit is served either straight from IDLE or when the awaited cell completes.
  always_comb begin
    sel_idx = (state == S_WAIT_FILL) ? wait_idx : match_idx;
    if (state == S_IDLE) begin
      do_hit = accept && match_found && match_valid;
    end else if (state == S_WAIT_FILL) begin
      do_hit = cell_available[wait_idx] || (ent[wait_idx] == E_VALID);
    end else begin
      do_hit = 1'b0;
    end
  end

  // Controller FSM, per-cell entry tracking and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      next_addr   <= '0;
      miss_addr   <= '0;
      alloc_idx   <= '0;
      wait_idx    <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_data   <= '0;
      cell_enable <= '0;
      cell_addr   <= '0;
      cell_stale  <= '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        ent[i] <= E_INVALID;
        tag[i] <= '0;
      end
    end else begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      cell_enable <= '0;
      cell_addr   <= '0;

      // Background completions; the FSM actions below take precedence on the same cell.
      for (int i = 0; i < NUM_CELLS; i++) begin
        case (ent[i])
          E_FILL:  if (cell_available[i]) ent[i] <= E_VALID;
          E_DRAIN: if (cell_idle[i]) begin
                     ent[i]        <= E_INVALID;
                     cell_stale[i] <= 1'b0;
                   end
          default: ;
        endcase
      end

      if (do_hit) begin
        resp_valid     <= 1'b1;
        resp_hit       <= 1'b1;
        resp_data      <= cell_line[sel_idx];
        cell_enable    <= {{(NUM_CELLS-1){1'b0}}, 1'b1} << sel_idx;
        cell_addr      <= {{BLOCK_OFFSET_WIDTH{1'b0}}, next_addr};
        tag[sel_idx]   <= next_addr;
        ent[sel_idx]   <= E_FILL;
        next_addr      <= next_addr + LINE_AW'(1);
      end

      case (state)
        S_IDLE: begin
          if (accept && !match_found) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            miss_addr  <= req_line_addr;
            state      <= S_FLUSH;
          end else if (accept && !match_valid) begin
            wait_idx <= match_idx;
            state    <= S_WAIT_FILL;
          end
        end
        S_WAIT_FILL: begin
          if (do_hit) state <= S_IDLE;
        end
        S_FLUSH: begin
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (ent[i] == E_FILL) begin
              ent[i]        <= E_DRAIN;
              cell_stale[i] <= 1'b1;
            end else if (ent[i] == E_VALID) begin
              ent[i] <= E_INVALID;
            end
          end
          next_addr <= miss_addr + LINE_AW'(1);
          alloc_idx <= '0;
          state     <= S_ALLOC;
        end
        S_ALLOC: begin
          if (ent[alloc_idx] == E_INVALID && cell_idle[alloc_idx]) begin
            cell_enable    <= {{(NUM_CELLS-1){1'b0}}, 1'b1} << alloc_idx;
            cell_addr      <= {{BLOCK_OFFSET_WIDTH{1'b0}}, next_addr};
            tag[alloc_idx] <= next_addr;
            ent[alloc_idx] <= E_FILL;
            next_addr      <= next_addr + LINE_AW'(1);
            alloc_idx      <= alloc_idx + IDX_W'(1);
            if (alloc_idx == IDX_W'(NUM_CELLS - 1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SB_CTRL_STATS_EN
  // Saturating response counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
    end else begin
      if (resp_valid && resp_hit && !(&stat_hits)) stat_hits <= stat_hits + 32'd1;
      if (resp_valid && !resp_hit && !(&stat_misses)) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule
